loteria_ticket_scheduler: RTL and testbench

//  Shares one 5-digit lottery checker FSM among N player terminals. Arbitrates round-robin,

---
 rtl/loteria_ticket_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_loteria_ticket_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loteria_ticket_scheduler.sv
// loteria_ticket_scheduler
// Shares one 5-digit lottery checker among N_PLAYERS terminals. A round-robin
// arbiter picks one requester, the checker is cleared, the ticket digits are
// streamed as insert strobes (most significant nibble first), finish is
// strobed, and the checker verdict (or a timeout/invalid-digit error) is
// returned to the owner with a one-cycle ack.
//
// Ports
//   clk, reset          clock (posedge) and synchronous active-high reset
//   req[N]              level request per terminal, held until its ack
//   ticket[4*DIGITS*N]  terminal p ticket at [p*4*DIGITS +: 4*DIGITS]
//   grant[N]            one-hot owner of the checker, held GRANT..REPORT
//   ack[N]              one-cycle pulse to the owner with the verdict
//   prize, win, err     verdict, valid with ack
//   busy                high whenever the scheduler is not idle
//   chk_reset           checker reset (CLEAR state or reset), combinational
//   chk_num, chk_insert digit and its one-cycle insert strobe
//   chk_finish          one-cycle finish strobe
//   chk_done/prize/win  checker verdict inputs
//
// Optional feature (macro LOTERIA_STATS_EN): adds stat_played / stat_wins,
// saturating 16-bit counters of acks issued and acks carrying win=1.
module loteria_ticket_scheduler #(
  parameter int N_PLAYERS = 4,
  parameter int DIGITS    = 5,
  parameter int TIMEOUT   = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PLAYERS-1:0]          req,
  input  logic [4*DIGITS*N_PLAYERS-1:0] ticket,
  output logic [N_PLAYERS-1:0]          grant,
  output logic [N_PLAYERS-1:0]          ack,
  output logic [1:0]                    prize,
  output logic                          win,
  output logic                          err,
  output logic                          busy,
  output logic                          chk_reset,
  output logic [3:0]                    chk_num,
  output logic                          chk_insert,
  output logic                          chk_finish,
`ifdef LOTERIA_STATS_EN
  output logic [15:0]                   stat_played,
  output logic [15:0]                   stat_wins,
`endif
  input  logic                          chk_done,
  input  logic [1:0]                    chk_prize,
  input  logic                          chk_win
);

  localparam int OW  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int TW  = 4 * DIGITS;
  localparam int DW  = $clog2(DIGITS + 1);
  localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEND, S_FINISH, S_WAIT, S_REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [TW-1:0]        ticket_q, ticket_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [TMW-1:0]       timer_q, timer_d;
  logic [N_PLAYERS-1:0] grant_q, grant_d;
  logic [N_PLAYERS-1:0] ack_q, ack_d;
  logic [1:0]           prize_q, prize_d;
  logic                 win_q, win_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [3:0]           num_q, num_d;
  logic                 insert_q, insert_d;
  logic                 finish_q, finish_d;

  logic                 found_s;
  int                   pick_s;
  logic [TW-1:0]        sel_ticket_s;

  // Digit k of a ticket, k=0 is the most significant nibble.
  function automatic logic [3:0] digit_at(input logic [TW-1:0] t, input int k);
    return t[(DIGITS-1-k)*4 +: 4];
  endfunction

  // A ticket is unusable if any nibble is not a decimal digit.
  function automatic logic has_bad_digit(input logic [TW-1:0] t);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[k*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Round-robin scan: first requester at or after the pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = 0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= N_PLAYERS) idx = idx - N_PLAYERS;
      if (!found_s && req[idx]) begin
        found_s = 1'b1;
        pick_s  = idx;
      end
    end
    sel_ticket_s = ticket[pick_s*TW +: TW];
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    ticket_d = ticket_q;
    dcnt_d   = dcnt_q;
    timer_d  = timer_q;
    grant_d  = grant_q;
    ack_d    = '0;
    prize_d  = 2'd0;
    win_d    = 1'b0;
    err_d    = 1'b0;
    num_d    = 4'd0;
    insert_d = 1'b0;
    finish_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          owner_d          = OW'(pick_s);
          ticket_d         = sel_ticket_s;
          grant_d          = '0;
          grant_d[pick_s]  = 1'b1;
          rr_d             = (pick_s == N_PLAYERS - 1) ? '0 : OW'(pick_s + 1);
          if (has_bad_digit(sel_ticket_s)) begin
            // Invalid ticket: report straight away, checker untouched.
            state_d        = S_REPORT;
            ack_d[pick_s]  = 1'b1;
            err_d          = 1'b1;
          end else begin
            state_d        = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d  = S_SEND;
        insert_d = 1'b1;
        num_d    = digit_at(ticket_q, 0);
        dcnt_d   = DW'(1);
      end
      S_SEND: begin
        if (dcnt_q == DW'(DIGITS)) begin
          state_d  = S_FINISH;
          finish_d = 1'b1;
        end else begin
          insert_d = 1'b1;
          num_d    = digit_at(ticket_q, int'(dcnt_q));
          dcnt_d   = dcnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_WAIT;
        timer_d = '0;
        dcnt_d  = '0;
      end
      S_WAIT: begin
        if (chk_done) begin
          state_d         = S_REPORT;
          ack_d[owner_q]  = 1'b1;
          prize_d         = chk_prize;
          win_d           = chk_win;
        end else if (timer_q == TMW'(TIMEOUT - 1)) begin
          state_d         = S_REPORT;
          ack_d[owner_q]  = 1'b1;
          err_d           = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      ticket_q <= '0;
      dcnt_q   <= '0;
      timer_q  <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      prize_q  <= 2'd0;
      win_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      num_q    <= 4'd0;
      insert_q <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      ticket_q <= ticket_d;
      dcnt_q   <= dcnt_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      prize_q  <= prize_d;
      win_q    <= win_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      num_q    <= num_d;
      insert_q <= insert_d;
      finish_q <= finish_d;
    end
  end

  // The checker must also be held in reset while this block is in reset.
  assign chk_reset  = reset | (state_q == S_CLEAR);
  assign grant      = grant_q;
  assign ack        = ack_q;
  assign prize      = prize_q;
  assign win        = win_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign chk_num    = num_q;
  assign chk_insert = insert_q;
  assign chk_finish = finish_q;

`ifdef LOTERIA_STATS_EN
  logic [15:0] played_q, wins_q;

  // Saturating usage counters, stepped on the edge that raises ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      played_q <= 16'd0;
      wins_q   <= 16'd0;
    end else begin
      if ((|ack_d) && (played_q != 16'hFFFF)) played_q <= played_q + 16'd1;
      if ((|ack_d) && win_d && (wins_q != 16'hFFFF)) wins_q <= wins_q + 16'd1;
    end
  end

  assign stat_played = played_q;
  assign stat_wins   = wins_q;
`endif

endmodule

// File: tb/tb_loteria_ticket_scheduler.sv
// Self-checking bench for loteria_ticket_scheduler: a vector table of single
// tickets plus hand-written round-robin, mid-SEND reset and statistics
// sequences. Expected digits and acks go into scoreboard queues when a
// request is driven; a monitor pops and compares them as the DUT emits them.
// Outputs are sampled 1 time unit after the rising edge; "cycle k" below
// means the value registered at rising edge k.
module tb_loteria_ticket_scheduler;

  localparam int N  = 4;
  localparam int D  = 5;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [4*D*N-1:0] ticket;
  logic [N-1:0]   grant, ack;
  logic [1:0]     prize;
  logic           win, err, busy;
  logic           chk_reset;
  logic [3:0]     chk_num;
  logic           chk_insert, chk_finish;
  logic           chk_done;
  logic [1:0]     chk_prize;
  logic           chk_win;
`ifdef LOTERIA_STATS_EN
  logic [15:0]    stat_played, stat_wins;
`endif

  loteria_ticket_scheduler #(.N_PLAYERS(N), .DIGITS(D), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .ticket(ticket),
    .grant(grant), .ack(ack), .prize(prize), .win(win), .err(err), .busy(busy),
    .chk_reset(chk_reset), .chk_num(chk_num), .chk_insert(chk_insert),
    .chk_finish(chk_finish),
`ifdef LOTERIA_STATS_EN
    .stat_played(stat_played), .stat_wins(stat_wins),
`endif
    .chk_done(chk_done), .chk_prize(chk_prize), .chk_win(chk_win)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         player;
    logic [1:0] prize;
    logic       win;
    logic       err;
  } ack_exp_t;

  typedef struct {
    int          player;
    logic [19:0] tkt;
    logic        bad_tkt;
    int          delay;    // checker done delay after finish, -1 = never
    logic [1:0]  cprize;
    logic        cwin;
    logic [1:0]  eprize;
    logic        ewin;
    logic        eerr;
  } vec_t;

  ack_exp_t   exp_acks[$];
  logic [3:0] exp_digits[$];
  vec_t       vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares emitted digits and acks against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
      if (chk_insert) begin
        if (exp_digits.size() == 0) begin
          chk("insert_unexpected", 32'd1, 32'd0);
        end else begin
          chk("digit", 32'(chk_num), 32'(exp_digits.pop_front()));
        end
      end
      if (ack != '0) begin
        if (exp_acks.size() == 0) begin
          chk("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          ack_exp_t e;
          logic [N-1:0] oh;
          e = exp_acks.pop_front();
          oh = '0;
          oh[e.player] = 1'b1;
          chk("ack_vec", 32'(ack), 32'(oh));
          chk("ack_grant", 32'(grant), 32'(oh));
          chk("prize", 32'(prize), 32'(e.prize));
          chk("win", 32'(win), 32'(e.win));
          chk("err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  // Queue expectations for one ticket of player p.
  task automatic expect_ticket(input int p, input logic [19:0] tkt, input logic bad_tkt,
                               input logic [1:0] ep, input logic ew, input logic ee);
    ack_exp_t e;
    if (!bad_tkt) begin
      for (int k = 0; k < D; k++) exp_digits.push_back(tkt[(D-1-k)*4 +: 4]);
    end
    e.player = p; e.prize = ep; e.win = ew; e.err = ee;
    exp_acks.push_back(e);
  endtask

  // Checker model plus request handling until n_acks acks have been seen.
  task automatic serve(input int n_acks, input int delay, input logic [1:0] cp, input logic cw,
                       output int fin_c, output int ack_c, output int ins_c);
    int acks, cnt;
    logic waiting;
    acks = 0; cnt = 0; waiting = 1'b0;
    fin_c = -1; ack_c = -1; ins_c = -1;
    for (int c = 0; c < 400 && acks < n_acks; c++) begin
      @(posedge clk);
      #1;
      if (chk_insert && ins_c < 0) ins_c = cyc;
      if (waiting) begin
        cnt--;
        if (delay >= 0 && cnt <= 0) begin
          chk_done = 1'b1; chk_prize = cp; chk_win = cw;
        end
      end
      if (chk_finish) begin
        waiting = 1'b1; cnt = delay; fin_c = cyc;
      end
      if (ack != '0) begin
        acks++;
        ack_c = cyc;
        waiting = 1'b0;
        chk_done = 1'b0; chk_prize = 2'd0; chk_win = 1'b0;
        if (acks == n_acks) req = '0;
      end
    end
    if (acks < n_acks) chk("serve_budget", 32'(acks), 32'(n_acks));
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int e0, fin_c, ack_c, ins_c, nins;

  initial begin
    reset = 1'b1; req = '0; ticket = '0;
    chk_done = 1'b0; chk_prize = 2'd0; chk_win = 1'b0;

    vecs[0] = '{0, 20'h50967, 1'b0,  2, 2'd1, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{1, 20'h12345, 1'b0,  1, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[2] = '{2, 20'h50A67, 1'b1,  1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b1};
    vecs[3] = '{3, 20'h99999, 1'b0,  3, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{1, 20'h00000, 1'b0, -1, 2'd2, 1'b1, 2'd0, 1'b0, 1'b1};
    vecs[5] = '{0, 20'hF0000, 1'b1,  1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b1};
    vecs[6] = '{3, 20'h81239, 1'b0,  5, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[7] = '{2, 20'h9999A, 1'b1,  1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_insert", 32'(chk_insert), 32'd0);
    chk("rst_finish", 32'(chk_finish), 32'd0);
    chk("rst_outs", 32'({prize, win, err, chk_num}), 32'd0);
    chk("rst_chk_reset", 32'(chk_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_chk_reset", 32'(chk_reset), 32'd0);

    // Table of single-ticket services.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      ticket = '0;
      ticket[vecs[v].player*4*D +: 4*D] = vecs[v].tkt;
      req = '0;
      req[vecs[v].player] = 1'b1;
      expect_ticket(vecs[v].player, vecs[v].tkt, vecs[v].bad_tkt,
                    vecs[v].eprize, vecs[v].ewin, vecs[v].eerr);
      e0 = cyc + 1;
      serve(1, vecs[v].delay, vecs[v].cprize, vecs[v].cwin, fin_c, ack_c, ins_c);
      if (vecs[v].bad_tkt) begin
        chk("inv_ack_cycle", 32'(ack_c - e0), 32'd0);
        chk("inv_no_finish", 32'(fin_c), 32'hFFFF_FFFF);
        chk("inv_no_insert", 32'(ins_c), 32'hFFFF_FFFF);
      end else begin
        chk("first_insert_cycle", 32'(ins_c - e0), 32'd1);
        chk("finish_cycle", 32'(fin_c - e0), 32'd6);
        if (vecs[v].delay < 0) chk("timeout_latency", 32'(ack_c - fin_c), 32'(TO + 1));
        else chk("ack_latency", 32'(ack_c - fin_c), 32'(vecs[v].delay + 1));
      end
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // All four requesting continuously: grants 0,1,2,3,0.
    do_reset();
    ticket = {20'h08642, 20'h97531, 20'h24680, 20'h13579};
    expect_ticket(0, 20'h13579, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_ticket(1, 20'h24680, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_ticket(2, 20'h97531, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_ticket(3, 20'h08642, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_ticket(0, 20'h13579, 1'b0, 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    req = 4'b1111;
    serve(5, 1, 2'd2, 1'b1, fin_c, ack_c, ins_c);
    repeat (2) @(negedge clk);

    // Reset during the third digit: aborted with no ack, then re-served.
    ticket = '0;
    ticket[19:0] = 20'h50967;
    exp_digits.push_back(4'd5); exp_digits.push_back(4'd0); exp_digits.push_back(4'd9);
    expect_ticket(0, 20'h50967, 1'b0, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    req = 4'b0001;
    nins = 0;
    for (int c = 0; c < 30 && nins < 3; c++) begin
      @(posedge clk);
      #1;
      if (chk_insert) nins++;
    end
    chk("abort_inserts_seen", 32'(nins), 32'd3);
    reset = 1'b1;
    #1;
    chk("abort_chk_reset", 32'(chk_reset), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_outs", 32'({grant, ack, busy, chk_insert, chk_finish}), 32'd0);
    reset = 1'b0;
    serve(1, 1, 2'd1, 1'b1, fin_c, ack_c, ins_c);
    chk("restart_finish_seen", 32'(fin_c >= 0), 32'd1);
    repeat (2) @(negedge clk);

`ifdef LOTERIA_STATS_EN
    // Statistics: three served tickets, two winners.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      ticket = '0;
      ticket[s*4*D +: 4*D] = 20'h12345;
      req = '0;
      req[s] = 1'b1;
      expect_ticket(s, 20'h12345, 1'b0, 2'd1, (s != 2), 1'b0);
      serve(1, 1, 2'd1, (s != 2), fin_c, ack_c, ins_c);
    end
    @(negedge clk);
    chk("stat_played", 32'(stat_played), 32'd3);
    chk("stat_wins", 32'(stat_wins), 32'd2);
`endif

    repeat (3) @(negedge clk);
    chk("digits_left", 32'(exp_digits.size()), 32'd0);
    chk("acks_left", 32'(exp_acks.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
